// File: rtl/vx_axi_read_slave.sv
// AXI4 read slave: queued AR bursts are expanded into word reads on a simple memory port,
// and memory data is re-joined with per-beat metadata to return R beats in order.
module vx_axi_read_slave #(
  parameter int unsigned AXI_DATA_WIDTH  = 512,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_TID_WIDTH   = 8,
  parameter int unsigned REQ_QUEUE_DEPTH = 4,
  parameter int unsigned RSP_BUF_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_TID_WIDTH-1:0]  s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic [1:0]                s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arqos,
  input  logic [3:0]                s_axi_arregion,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic                      s_axi_rlast,
  output logic [AXI_TID_WIDTH-1:0]  s_axi_rid,
  output logic [1:0]                s_axi_rresp,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [AXI_ADDR_WIDTH-$clog2(AXI_DATA_WIDTH/8)-1:0] mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int unsigned SizeLog2 = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned WordW    = AXI_ADDR_WIDTH - SizeLog2;
  localparam int unsigned QW       = $clog2(REQ_QUEUE_DEPTH);
  localparam int unsigned BW       = $clog2(RSP_BUF_DEPTH);

  logic unused_ok;
  assign unused_ok = ^{s_axi_araddr, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_arregion};

  // Request queue: legality is decided at acceptance so only err/fixed flags are stored.
  logic [WordW-1:0]         rq_word  [REQ_QUEUE_DEPTH];
  logic [AXI_TID_WIDTH-1:0] rq_id    [REQ_QUEUE_DEPTH];
  logic [7:0]               rq_len   [REQ_QUEUE_DEPTH];
  logic                     rq_fixed [REQ_QUEUE_DEPTH];
  logic                     rq_err   [REQ_QUEUE_DEPTH];
  logic [QW-1:0]            rq_wr_q, rq_rd_q;
  logic [QW:0]              rq_cnt_q;
  logic                     rq_push, rq_pop, rq_full, rq_empty, ar_err, rst_done_q;

  assign rq_full       = (rq_cnt_q == (QW+1)'(REQ_QUEUE_DEPTH));
  assign rq_empty      = (rq_cnt_q == '0);
  assign s_axi_arready = rst_done_q && !rq_full;
  assign rq_push       = s_axi_arvalid && s_axi_arready;
  assign ar_err        = !((s_axi_arburst == 2'b00 || s_axi_arburst == 2'b01) &&
                           s_axi_arsize == 3'(SizeLog2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_done_q <= 1'b0;
      rq_wr_q    <= '0;
      rq_rd_q    <= '0;
      rq_cnt_q   <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (rq_push) rq_wr_q <= rq_wr_q + QW'(1);
      if (rq_pop)  rq_rd_q <= rq_rd_q + QW'(1);
      rq_cnt_q <= rq_cnt_q + (QW+1)'(rq_push) - (QW+1)'(rq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_word[rq_wr_q]  <= s_axi_araddr[AXI_ADDR_WIDTH-1:SizeLog2];
      rq_id[rq_wr_q]    <= s_axi_arid;
      rq_len[rq_wr_q]   <= s_axi_arlen;
      rq_fixed[rq_wr_q] <= (s_axi_arburst == 2'b00);
      rq_err[rq_wr_q]   <= ar_err;
    end
  end

  // Burst engine on the queue head
  logic [7:0] beat_q;
  logic       issue, beat_last, hd_err, mq_full;

  assign hd_err        = rq_err[rq_rd_q];
  assign beat_last     = (beat_q == rq_len[rq_rd_q]);
  assign mem_req_valid = !rq_empty && !hd_err && !mq_full;
  assign mem_req_addr  = rq_fixed[rq_rd_q] ? rq_word[rq_rd_q]
                                           : rq_word[rq_rd_q] + WordW'(beat_q);
  assign issue         = !rq_empty && !mq_full && (hd_err || mem_req_ready);
  assign rq_pop        = issue && beat_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
    end else if (issue) begin
      beat_q <= beat_last ? 8'd0 : beat_q + 8'd1;
    end
  end

  // Metadata FIFO (one entry per issued beat) and data FIFO (one per memory response)
  logic [AXI_TID_WIDTH-1:0]  mq_id   [RSP_BUF_DEPTH];
  logic                      mq_last [RSP_BUF_DEPTH];
  logic                      mq_err  [RSP_BUF_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] dq_data [RSP_BUF_DEPTH];
  logic [BW-1:0]             mq_wr_q, mq_rd_q, dq_wr_q, dq_rd_q;
  logic [BW:0]               mq_cnt_q, dq_cnt_q;
  logic                      mq_empty, dq_empty, mq_hd_err, r_fire, dq_pop;

  assign mq_full   = (mq_cnt_q == (BW+1)'(RSP_BUF_DEPTH));
  assign mq_empty  = (mq_cnt_q == '0);
  assign dq_empty  = (dq_cnt_q == '0);
  assign mq_hd_err = mq_err[mq_rd_q];
  assign r_fire    = s_axi_rvalid && s_axi_rready;
  assign dq_pop    = r_fire && !mq_hd_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mq_wr_q  <= '0;
      mq_rd_q  <= '0;
      mq_cnt_q <= '0;
      dq_wr_q  <= '0;
      dq_rd_q  <= '0;
      dq_cnt_q <= '0;
    end else begin
      if (issue)         mq_wr_q <= mq_wr_q + BW'(1);
      if (r_fire)        mq_rd_q <= mq_rd_q + BW'(1);
      if (mem_rsp_valid) dq_wr_q <= dq_wr_q + BW'(1);
      if (dq_pop)        dq_rd_q <= dq_rd_q + BW'(1);
      mq_cnt_q <= mq_cnt_q + (BW+1)'(issue) - (BW+1)'(r_fire);
      dq_cnt_q <= dq_cnt_q + (BW+1)'(mem_rsp_valid) - (BW+1)'(dq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      mq_id[mq_wr_q]   <= rq_id[rq_rd_q];
      mq_last[mq_wr_q] <= beat_last;
      mq_err[mq_wr_q]  <= hd_err;
    end
    if (mem_rsp_valid) dq_data[dq_wr_q] <= mem_rsp_data;
  end

  // Outputs are forced to zero whenever no beat is presented, which also covers reset.
  assign s_axi_rvalid = !mq_empty && (mq_hd_err || !dq_empty);
  assign s_axi_rid    = s_axi_rvalid ? mq_id[mq_rd_q] : '0;
  assign s_axi_rlast  = s_axi_rvalid && mq_last[mq_rd_q];
  assign s_axi_rresp  = (s_axi_rvalid && mq_hd_err) ? 2'b10 : 2'b00;
  assign s_axi_rdata  = (s_axi_rvalid && !mq_hd_err) ? dq_data[dq_rd_q] : '0;

endmodule

// File: tb/tb_vx_axi_read_slave.sv
// Bench for vx_axi_read_slave: transaction-level model (expected address and beat queues built
// from each accepted AR) checked every cycle, plus directed scenarios with literal expectations.
module tb_vx_axi_read_slave;
  localparam int unsigned DW = 512;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned BD = 4;
  localparam int unsigned WW = AW - 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [AW-1:0] s_axi_araddr;
  logic [TW-1:0] s_axi_arid, s_axi_rid;
  logic [7:0] s_axi_arlen;
  logic [2:0] s_axi_arsize, s_axi_arprot;
  logic [1:0] s_axi_arburst, s_axi_arlock, s_axi_rresp;
  logic [3:0] s_axi_arcache, s_axi_arqos, s_axi_arregion;
  logic [DW-1:0] s_axi_rdata, mem_rsp_data;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [WW-1:0] mem_req_addr;

  vx_axi_read_slave dut (
    .clk(clk), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [TW-1:0] id; logic last; logic err; logic [WW-1:0] word; } beat_t;
  typedef struct { logic [TW-1:0] id; logic last; logic [1:0] resp; logic [DW-1:0] data; } rlog_t;

  beat_t         exp_beat[$];
  logic [WW-1:0] exp_addr[$];
  logic [WW-1:0] pend[$];
  rlog_t         r_log[$];
  logic [WW-1:0] addr_log[$];
  int unsigned   mem_cyc_log[$];
  int unsigned   cyc = 0, vectors = 0, miscompares = 0;
  int unsigned   mem_issued = 0, legal_done = 0, rsp_seq = 0;
  int unsigned   ar_cyc = 0, rsp_cyc_last = 0, r_cyc_last = 0;
  int            rready_mode = 0, mready_mode = 0, rsp_mode = 0;

  logic          p_hold = 1'b0;
  logic [TW-1:0] p_id;
  logic          p_last;
  logic [1:0]    p_resp;
  logic [DW-1:0] p_data;

  // Memory content: depends on the word address and on the response's position in the stream.
  function automatic logic [DW-1:0] mem_word(input logic [WW-1:0] w, input int unsigned seq);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++)
      d[i*32 +: 32] = ({6'(seq), w} * 32'h9E3779B1) ^ (32'(i) * 32'h7F4A7C15) ^ 32'(seq);
    return d;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare process
  always @(negedge clk) begin
    if (reset) begin
      check("reset_arready", s_axi_arready, 0);
      check("reset_rvalid", s_axi_rvalid, 0);
      check("reset_mem_req_valid", mem_req_valid, 0);
      check("reset_r_ctl", {s_axi_rid, s_axi_rlast, s_axi_rresp}, 0);
      check("reset_rdata", s_axi_rdata, 0);
      exp_beat.delete(); exp_addr.delete(); pend.delete();
      mem_issued = 0; legal_done = 0; rsp_seq = 0; p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        check("r_stable_valid", s_axi_rvalid, 1);
        check("r_stable_ctl", {s_axi_rid, s_axi_rlast, s_axi_rresp}, {p_id, p_last, p_resp});
        check("r_stable_data", s_axi_rdata, p_data);
      end
      if (s_axi_rvalid && s_axi_rready) begin
        check("r_beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          beat_t b;
          b = exp_beat.pop_front();
          check("rid", s_axi_rid, b.id);
          check("rlast", s_axi_rlast, b.last);
          check("rresp", s_axi_rresp, b.err ? 2'b10 : 2'b00);
          check("rdata", s_axi_rdata, b.err ? '0 : mem_word(b.word, legal_done));
          if (!b.err) legal_done++;
        end
        r_log.push_back('{s_axi_rid, s_axi_rlast, s_axi_rresp, s_axi_rdata});
        r_cyc_last = cyc;
      end
      if (mem_req_valid) begin
        check("mem_req_expected", exp_addr.size() != 0, 1);
        if (mem_req_ready && exp_addr.size() != 0) begin
          check("mem_req_addr", mem_req_addr, exp_addr.pop_front());
          pend.push_back(mem_req_addr);
          addr_log.push_back(mem_req_addr);
          mem_cyc_log.push_back(cyc);
          mem_issued++;
          check("outstanding_bound", (mem_issued - legal_done) <= BD, 1);
        end
      end
      if (mem_rsp_valid) rsp_cyc_last = cyc;
      p_hold = s_axi_rvalid && !s_axi_rready;
      p_id = s_axi_rid; p_last = s_axi_rlast; p_resp = s_axi_rresp; p_data = s_axi_rdata;
      if (s_axi_arvalid && s_axi_arready) begin
        logic err;
        logic [WW-1:0] w;
        err = !((s_axi_arburst == 2'b00 || s_axi_arburst == 2'b01) && s_axi_arsize == 3'd6);
        w = s_axi_araddr[AW-1:6];
        for (int k = 0; k <= int'(s_axi_arlen); k++) begin
          logic [WW-1:0] wk;
          wk = (s_axi_arburst == 2'b00) ? w : w + WW'(k);
          exp_beat.push_back('{s_axi_arid, k == int'(s_axi_arlen), err, wk});
          if (!err) exp_addr.push_back(wk);
        end
        ar_cyc = cyc;
      end
    end
  end

  // In-order memory responder
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (!reset && pend.size() != 0 && (rsp_mode == 0 || $urandom_range(0, 2) != 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = mem_word(pend.pop_front(), rsp_seq);
        rsp_seq++;
      end
    end
  end

  // Ready drivers: mode 0 = always 1, 1 = random, 2 = always 0
  initial begin
    s_axi_rready = 1'b0;
    mem_req_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_axi_rready  = (rready_mode == 0) || (rready_mode == 1 && $urandom_range(0, 1) == 1);
      mem_req_ready = (mready_mode == 0) || (mready_mode == 1 && $urandom_range(0, 1) == 1);
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    r_log.delete(); addr_log.delete(); mem_cyc_log.delete();
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [TW-1:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arid = id; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arlock = 2'($urandom()); s_axi_arcache = 4'($urandom()); s_axi_arprot = 3'($urandom());
    s_axi_arqos = 4'($urandom()); s_axi_arregion = 4'($urandom());
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); ok = s_axi_arready;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    check("ar_accepted", ok, 1);
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while ((exp_beat.size() != 0 || pend.size() != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check("drain_beats_left", exp_beat.size(), 0);
  endtask

  task automatic wait_issued(input int unsigned cnt);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (addr_log.size() >= cnt) break;
    end
    check("issued_count", addr_log.size(), cnt);
  endtask

  initial begin
    logic [2:0] sz;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [AW-1:0] a;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = '0; s_axi_arcache = '0;
    s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arregion = '0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    @(negedge clk); check("arready_after_reset", s_axi_arready, 1);
    @(posedge clk); #1;

    // Single beat
    clear_logs();
    send_ar(32'h1000, 8'd5, 8'd0, 3'd6, 2'b01);
    wait_drain(200);
    check("single_nreq", addr_log.size(), 1);
    check("single_addr", addr_log[0], 26'h40);
    check("single_nbeat", r_log.size(), 1);
    check("single_ctl", {r_log[0].id, r_log[0].last, r_log[0].resp}, {8'd5, 1'b1, 2'b00});
    check("single_data", r_log[0].data, mem_word(26'h40, 0));
    check("single_req_latency", mem_cyc_log[0] - ar_cyc, 1);
    check("single_r_latency", r_cyc_last - rsp_cyc_last, 1);

    // INCR burst
    clear_logs();
    send_ar(32'h2000, 8'd7, 8'd3, 3'd6, 2'b01);
    wait_drain(200);
    for (int k = 0; k < 4; k++) begin
      check("incr_addr", addr_log[k], 26'h80 + 26'(k));
      check("incr_consecutive", mem_cyc_log[k] - mem_cyc_log[0], k);
      check("incr_rlast", r_log[k].last, k == 3);
    end

    // FIXED burst followed by an error burst
    clear_logs();
    send_ar(32'h2000, 8'd2, 8'd1, 3'd6, 2'b00);
    send_ar(32'h2000, 8'd3, 8'd1, 3'd5, 2'b01);
    wait_drain(200);
    check("fixed_nreq", addr_log.size(), 2);
    check("fixed_addr0", addr_log[0], 26'h80);
    check("fixed_addr1", addr_log[1], 26'h80);
    check("fixed_nbeat", r_log.size(), 4);
    check("fixed_beat1", {r_log[1].id, r_log[1].last, r_log[1].resp}, {8'd2, 1'b1, 2'b00});
    check("err_beat2", {r_log[2].id, r_log[2].last, r_log[2].resp}, {8'd3, 1'b0, 2'b10});
    check("err_beat3", {r_log[3].id, r_log[3].last, r_log[3].resp}, {8'd3, 1'b1, 2'b10});
    check("err_data", r_log[3].data, 0);

    // R backpressure limits outstanding reads
    rready_mode = 2;
    wait_cycles(2);
    clear_logs();
    send_ar(32'h3000, 8'd4, 8'd7, 3'd6, 2'b01);
    wait_cycles(20);
    @(negedge clk);
    check("bp_reads_held", addr_log.size(), 4);
    check("bp_req_valid", mem_req_valid, 0);
    @(posedge clk); #1;
    rready_mode = 0;
    wait_drain(300);
    check("bp_reads_total", addr_log.size(), 8);
    check("bp_last_addr", addr_log[7], 26'hC7);
    check("bp_nbeat", r_log.size(), 8);
    check("bp_rlast", {r_log[3].last, r_log[7].last}, 2'b01);

    // Request queue full
    mready_mode = 2;
    wait_cycles(2);
    clear_logs();
    for (int i = 0; i < 4; i++) send_ar(32'h6000 + 32'(i * 256), 8'(10 + i), 8'd1, 3'd6, 2'b01);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h7000; s_axi_arid = 8'd20; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd6; s_axi_arburst = 2'b01;
    wait_cycles(5);
    @(negedge clk); check("qfull_arready", s_axi_arready, 0);
    @(posedge clk); #1;
    mready_mode = 0;
    wait_issued(2);
    check("qfull_arready_at_pop", s_axi_arready, 0);
    @(negedge clk); check("qfull_arready_after_pop", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    wait_drain(300);
    check("qfull_nbeat", r_log.size(), 9);
    check("qfull_tail_id", r_log[8].id, 20);

    // Reset in the middle of a burst
    clear_logs();
    send_ar(32'h4000, 8'd6, 8'd3, 3'd6, 2'b01);
    wait_issued(2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_outputs", {s_axi_arready, s_axi_rvalid, mem_req_valid, s_axi_rlast}, 0);
    wait_cycles(2);
    reset = 1'b0;
    clear_logs();
    wait_cycles(1);
    @(negedge clk); check("midrst_arready_rise", s_axi_arready, 1);
    @(posedge clk); #1;
    send_ar(32'h5000, 8'd9, 8'd0, 3'd6, 2'b01);
    wait_drain(200);
    check("midrst_nreq", addr_log.size(), 1);
    check("midrst_addr", addr_log[0], 26'h140);
    check("midrst_nbeat", r_log.size(), 1);
    check("midrst_rid", r_log[0].id, 9);

    // Randomized traffic against the model
    rready_mode = 1; mready_mode = 1; rsp_mode = 1;
    for (int n = 0; n < 80; n++) begin
      sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd6;
      bt = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      ln = 8'($urandom_range(0, 7));
      a = $urandom();
      if (n == 30) begin a = 32'hFFFF_FFC0; sz = 3'd6; bt = 2'b01; ln = 8'd3; end
      if (n == 50) rready_mode = 0;
      if (n == 60) begin rready_mode = 1; mready_mode = 0; rsp_mode = 0; end
      send_ar(a, 8'($urandom()), ln, sz, bt);
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 5));
    end
    wait_drain(5000);
    check("final_addr_queue", exp_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_axi_read_slave.md
VX_AXI_READ_SLAVE -- requirements
Module: VX_axi_read_slave

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 512, meaning R data width in bits (power of 2, >=8).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AR byte-address width.
REQ-003 SHALL have parameter AXI_TID_WIDTH, default 8, meaning ARID/RID width.
REQ-004 SHALL have parameter REQ_QUEUE_DEPTH, default 4, meaning the AR request queue entries (power of 2, >=2).
REQ-005 SHALL have parameter RSP_BUF_DEPTH, default 4, meaning the maximum outstanding beats (power of 2, >=2).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-007 SHALL have these AR ports: s_axi_arvalid in 1; s_axi_arready out 1; s_axi_araddr in AXI_ADDR_WIDTH; s_axi_arid in AXI_TID_WIDTH; s_axi_arlen in 8; s_axi_arsize in 3; s_axi_arburst in 2; s_axi_arlock in 2; s_axi_arcache in 4; s_axi_arprot in 3; s_axi_arqos in 4; s_axi_arregion in 4. The lock, cache, prot, qos and region inputs are accepted and ignored.
REQ-008 SHALL have these R ports: s_axi_rvalid out 1; s_axi_rready in 1; s_axi_rdata out AXI_DATA_WIDTH; s_axi_rlast out 1; s_axi_rid out AXI_TID_WIDTH; s_axi_rresp out 2.
REQ-009 SHALL have these memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out AXI_ADDR_WIDTH-log2(AXI_DATA_WIDTH/8), a word address; mem_rsp_valid in 1, with no backpressure; mem_rsp_data in AXI_DATA_WIDTH. Memory responses return in request order.

Function
REQ-010 SHALL accept an AR when s_axi_arvalid and s_axi_arready are both high, pushing the request into the request queue; s_axi_arready = queue not full.
REQ-011 The burst engine SHALL process the queue head only; the head is popped in the cycle its last beat is issued.
REQ-012 A burst SHALL be legal iff arburst is 00 (FIXED) or 01 (INCR) and arsize = log2(AXI_DATA_WIDTH/8); otherwise it is an error burst.
REQ-013 For a legal burst, the engine SHALL issue arlen+1 memory reads; beat k uses word address (araddr>>arsize)+k for INCR, or araddr>>arsize for FIXED; addresses wrap modulo 2^width.
REQ-014 For an error burst, the engine SHALL issue no memory reads and SHALL emit arlen+1 beats with rresp=2'b10 and rdata=0.
REQ-015 Each issued beat (a memory handshake, or one cycle per error beat) SHALL push {id, last, err} into a metadata FIFO of depth RSP_BUF_DEPTH; issue SHALL stall while that FIFO is full.
REQ-016 mem_rsp_data SHALL be pushed into a data FIFO of depth RSP_BUF_DEPTH; this FIFO cannot overflow because data count <= metadata count.
REQ-017 s_axi_rvalid SHALL equal metadata FIFO non-empty AND (head.err OR data FIFO non-empty).
REQ-018 On an R handshake, the block SHALL pop the metadata FIFO and, if head.err = 0, also the data FIFO.
REQ-019 For each R beat: rid = head.id; rlast = head.last (set on beat arlen); rresp = 2'b00 for legal beats; rdata = data FIFO head.
REQ-020 R outputs SHALL be stable while rvalid=1 and rready=0.
REQ-021 Beats SHALL return strictly in AR acceptance order, including error beats, which wait behind pending data beats.
REQ-022 Latency: an AR accepted at cycle 0 gives mem_req_valid at cycle 1 at the earliest; mem_rsp_valid at cycle t gives rvalid at cycle t+1.
REQ-023 Simultaneous AR push and head pop on a full queue SHALL hold arready=0, with no bypass.
REQ-024 Simultaneous push and pop on the FIFOs SHALL keep the count unchanged.
REQ-025 Throughput SHALL be one beat per cycle on the memory-request side and on the R side when not stalled.

Reset
REQ-026 While reset=1: s_axi_arready=0, s_axi_rvalid=0, mem_req_valid=0, s_axi_rlast=0, s_axi_rresp=0, s_axi_rid=0, s_axi_rdata=0, and all queues are empty with the beat counter at 0.
REQ-027 Reset asserted mid-burst SHALL discard all queued requests and outstanding beats; mem_rsp_valid during reset or after it for discarded reads is environment-excluded.
REQ-028 s_axi_arready SHALL rise in the first cycle after reset deassertion.

Verification
REQ-029 Single beat, 512-bit width: AR araddr=0x1000, arlen=0, arsize=6, arburst=01, id=5 -> one mem_req addr 0x40; rsp D -> one R beat with rdata=D, rid=5, rlast=1, rresp=0.
REQ-030 INCR burst: araddr=0x2000, arlen=3 -> mem_req addrs 0x80, 0x81, 0x82, 0x83 on consecutive cycles; rlast=1 on the 4th beat only.
REQ-031 FIXED burst: araddr=0x2000, arlen=1, arburst=00 -> mem_req addr 0x80 twice; arsize=5 with INCR arlen=1 id=3 queued behind it -> 2 beats with rresp=2'b10, rdata=0, rid=3, no mem_req, emitted after the FIXED beats.
REQ-032 Backpressure: rready=0, RSP_BUF_DEPTH=4, arlen=7 -> exactly 4 memory reads, then mem_req_valid=0; rready=1 -> the remaining 4 reads issue and 8 beats arrive in order.
REQ-033 Queue full: mem_req_ready=0, 5 ARs offered -> 4 accepted, arready=0 on the 5th until the head burst issues its last beat.
REQ-034 Reset mid-burst: assert reset during beat 2 of an arlen=3 burst -> all outputs 0 next cycle; after release, a new AR completes normally with no stale beats.
